// File: rtl/pipeline_result_collector_if.sv
// Result-collector bus: job control, pipeline taps and result handshake.
// The master side is the job controller / pipeline; the slave is the collector.
interface pipeline_result_collector_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   start;
    logic [COUNT_WIDTH-1:0] expectedCount;
    logic                   botValidIn;
    logic [37:0]            summedDataIn;
    logic [2:0]             pcoeffCountIn;
    logic                   resultReady;
    logic                   busy;
    logic                   resultValid;
    logic [63:0]            totalSum;
    logic [COUNT_WIDTH+2:0] totalPcoeff;
    logic [COUNT_WIDTH-1:0] resultsReceived;
    logic                   strayResult;
    logic                   sumOverflow;

    modport master (
        output start,
        output expectedCount,
        output botValidIn,
        output summedDataIn,
        output pcoeffCountIn,
        output resultReady,
        input  busy,
        input  resultValid,
        input  totalSum,
        input  totalPcoeff,
        input  resultsReceived,
        input  strayResult,
        input  sumOverflow
    );

    modport slave (
        input  start,
        input  expectedCount,
        input  botValidIn,
        input  summedDataIn,
        input  pcoeffCountIn,
        input  resultReady,
        output busy,
        output resultValid,
        output totalSum,
        output totalPcoeff,
        output resultsReceived,
        output strayResult,
        output sumOverflow
    );
endinterface

// File: rtl/pipeline_result_collector.sv
// Collects fullPipeline outputs on lag-delayed bot valids and accumulates
// per-job totals, handing them over on a valid/ready handshake.
module pipeline_result_collector #(
    parameter int OUTPUT_LAG  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    pipeline_result_collector_if.slave bus
);
    localparam int PW = COUNT_WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [OUTPUT_LAG-1:0]  lag_q, lag_d;
    logic [COUNT_WIDTH-1:0] expected_q, expected_d;
    logic [COUNT_WIDTH-1:0] received_q, received_d;
    logic [63:0]            total_sum_q, total_sum_d;
    logic [PW-1:0]          total_pcoeff_q, total_pcoeff_d;
    logic                   stray_q, stray_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;

    logic                   lag_valid;
    logic [64:0]            sum_ext;

    assign lag_valid = lag_q[OUTPUT_LAG-1];
    assign sum_ext   = {1'b0, total_sum_q} + {27'd0, bus.summedDataIn};

    always_comb begin
        // Only the strobe is delayed; data is tapped live from the pipeline.
        lag_d          = OUTPUT_LAG'({lag_q, bus.botValidIn});
        state_d        = state_q;
        expected_d     = expected_q;
        received_d     = received_q;
        total_sum_d    = total_sum_q;
        total_pcoeff_d = total_pcoeff_q;
        stray_d        = stray_q;
        overflow_d     = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                stray_d = stray_q | lag_valid;
                if (bus.start) begin
                    expected_d     = bus.expectedCount;
                    received_d     = '0;
                    total_sum_d    = '0;
                    total_pcoeff_d = '0;
                    stray_d        = lag_valid;
                    overflow_d     = 1'b0;
                    if (bus.expectedCount == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (lag_valid) begin
                    total_sum_d    = sum_ext[63:0];
                    overflow_d     = overflow_q | sum_ext[64];
                    total_pcoeff_d = total_pcoeff_q + PW'(bus.pcoeffCountIn);
                    received_d     = received_q + COUNT_WIDTH'(1);
                    if (received_d == expected_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                stray_d = stray_q | lag_valid;
                if (bus.resultReady) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d == S_RUN);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            lag_q          <= '0;
            expected_q     <= '0;
            received_q     <= '0;
            total_sum_q    <= '0;
            total_pcoeff_q <= '0;
            stray_q        <= 1'b0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            lag_q          <= lag_d;
            expected_q     <= expected_d;
            received_q     <= received_d;
            total_sum_q    <= total_sum_d;
            total_pcoeff_q <= total_pcoeff_d;
            stray_q        <= stray_d;
            overflow_q     <= overflow_d;
            busy_q         <= busy_d;
            valid_q        <= valid_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.resultValid     = valid_q;
    assign bus.totalSum        = total_sum_q;
    assign bus.totalPcoeff     = total_pcoeff_q;
    assign bus.resultsReceived = received_q;
    assign bus.strayResult     = stray_q;
    assign bus.sumOverflow     = overflow_q;
endmodule

// File: tb/tb_pipeline_result_collector.sv
// Bench for pipeline_result_collector: emulated pipeline data taps,
// job table plus corner-case sequences, scoreboard of expected results.
module tb_pipeline_result_collector;
    localparam int L  = 32;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_result_collector_if #(.COUNT_WIDTH(CW)) bus ();

    pipeline_result_collector #(
        .OUTPUT_LAG (L),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [63:0]   sum;
        logic [CW+2:0] pc;
        logic [CW-1:0] cnt;
        logic          stray;
        logic          ovf;
    } res_t;

    typedef struct {
        int          n;
        logic [37:0] d0;
        logic [37:0] dstep;
        logic [2:0]  pc;
        int          gap;
        logic [63:0] exp_sum;
        logic [CW+2:0] exp_pc;
    } vec_t;

    res_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_t  = 0;

    logic [37:0] sched_sum[int];
    logic [2:0]  sched_pc[int];

    always @(posedge clk) cyc <= cyc + 1;

    // Pipeline emulation: data appears OUTPUT_LAG cycles after its valid,
    // junk everywhere else.
    always @(negedge clk) begin
        if (sched_sum.exists(cyc)) begin
            bus.summedDataIn  = sched_sum[cyc];
            bus.pcoeffCountIn = sched_pc[cyc];
            sched_sum.delete(cyc);
            sched_pc.delete(cyc);
        end else begin
            bus.summedDataIn  = 38'({$urandom(), $urandom()});
            bus.pcoeffCountIn = 3'($urandom());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(logic [37:0] d, logic [2:0] p);
        bus.botValidIn     = 1'b1;
        sched_sum[cyc + L] = d;
        sched_pc[cyc + L]  = p;
        last_t             = cyc;
        @(negedge clk);
        bus.botValidIn = 1'b0;
    endtask

    task automatic start_job(int n);
        bus.start         = 1'b1;
        bus.expectedCount = CW'(n);
        @(negedge clk);
        bus.start         = 1'b0;
        bus.expectedCount = CW'($urandom());
    endtask

    task automatic wait_result(string name, int budget, output bit ok);
        int k = 0;
        while (bus.resultValid !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (bus.resultValid === 1'b1);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: resultValid=%b after %0d cycles, required 1",
                     name, bus.resultValid, k);
        end
    endtask

    task automatic compare_result(string name);
        res_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.sb: result with empty scoreboard, required none", name);
            return;
        end
        e = sb_q.pop_front();
        check({name, ".sum"},   bus.totalSum,        e.sum);
        check({name, ".pc"},    bus.totalPcoeff,     64'(e.pc));
        check({name, ".cnt"},   bus.resultsReceived, 64'(e.cnt));
        check({name, ".stray"}, bus.strayResult,     64'(e.stray));
        check({name, ".ovf"},   bus.sumOverflow,     64'(e.ovf));
        check({name, ".busy"},  bus.busy,            64'd0);
    endtask

    task automatic handshake(string name);
        bus.resultReady = 1'b1;
        @(negedge clk);
        bus.resultReady = 1'b0;
        check({name, ".valid_fall"}, bus.resultValid, 64'd0);
        check({name, ".idle_busy"},  bus.busy,        64'd0);
    endtask

    initial begin
        vec_t vecs[4];
        bit   ok;
        int   t0;

        vecs[0] = '{1, 38'h3F_FFFF_FFFF, 38'd0,    3'd7, 0,
                    64'd274877906943, 35'd7};
        vecs[1] = '{3, 38'd5,            38'd10,   3'd2, 0,
                    64'd45, 35'd6};
        vecs[2] = '{5, 38'd1000,         38'd1000, 3'd4, 2,
                    64'd15000, 35'd20};
        vecs[3] = '{8, 38'h3F_FFFF_FFFF, 38'd0,    3'd7, 1,
                    64'd2199023255544, 35'd56};

        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.expectedCount = '0;
        bus.botValidIn    = 1'b0;
        bus.resultReady   = 1'b0;
        repeat (3) @(negedge clk);

        check("reset.busy",  bus.busy,            64'd0);
        check("reset.valid", bus.resultValid,     64'd0);
        check("reset.sum",   bus.totalSum,        64'd0);
        check("reset.pc",    bus.totalPcoeff,     64'd0);
        check("reset.cnt",   bus.resultsReceived, 64'd0);
        check("reset.stray", bus.strayResult,     64'd0);
        check("reset.ovf",   bus.sumOverflow,     64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic job with exact completion timing.
        start_job(4);
        check("basic.busy_rise", bus.busy, 64'd1);
        sb_q.push_back('{sum: 64'd1000, pc: 35'd13, cnt: 32'd4, stray: 1'b0, ovf: 1'b0});
        send(38'd100, 3'd1);
        send(38'd200, 3'd2);
        send(38'd300, 3'd3);
        send(38'd400, 3'd7);
        t0 = last_t;
        while (cyc < t0 + L) @(negedge clk);
        check("basic.cnt_before", bus.resultsReceived, 64'd3);
        check("basic.sum_before", bus.totalSum,        64'd600);
        check("basic.valid_before", bus.resultValid,   64'd0);
        @(negedge clk);
        check("basic.valid_at_lag", bus.resultValid, 64'd1);
        compare_result("basic");
        handshake("basic");

        // Job table.
        for (int i = 0; i < 4; i++) begin
            start_job(vecs[i].n);
            check($sformatf("vec%0d.busy", i), bus.busy, 64'd1);
            sb_q.push_back('{sum: vecs[i].exp_sum, pc: vecs[i].exp_pc,
                             cnt: CW'(vecs[i].n), stray: 1'b0, ovf: 1'b0});
            for (int j = 0; j < vecs[i].n; j++) begin
                send(vecs[i].d0 + 38'(j) * vecs[i].dstep, vecs[i].pc);
                repeat (vecs[i].gap) @(negedge clk);
            end
            wait_result($sformatf("vec%0d", i), 200, ok);
            if (ok) compare_result($sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        // Zero-length job.
        start_job(0);
        check("zero.valid_next", bus.resultValid, 64'd1);
        sb_q.push_back('{sum: 64'd0, pc: 35'd0, cnt: 32'd0, stray: 1'b0, ovf: 1'b0});
        compare_result("zero");
        handshake("zero");

        // One valid beyond the expected count lands in DONE.
        start_job(2);
        sb_q.push_back('{sum: 64'd30, pc: 35'd3, cnt: 32'd2, stray: 1'b0, ovf: 1'b0});
        send(38'd10, 3'd1);
        send(38'd20, 3'd2);
        send(38'd30, 3'd4);
        wait_result("stray", 200, ok);
        if (ok) compare_result("stray");
        @(negedge clk);
        check("stray.flag", bus.strayResult,     64'd1);
        check("stray.sum",  bus.totalSum,        64'd30);
        check("stray.cnt",  bus.resultsReceived, 64'd2);
        handshake("stray");

        // Extra valid arrives on the handshake edge itself.
        start_job(1);
        sb_q.push_back('{sum: 64'd7, pc: 35'd1, cnt: 32'd1, stray: 1'b0, ovf: 1'b0});
        send(38'd7, 3'd1);
        send(38'd9, 3'd2);
        wait_result("overrun", 200, ok);
        if (ok) compare_result("overrun");
        handshake("overrun");
        check("overrun.stray", bus.strayResult, 64'd1);
        check("overrun.sum",   bus.totalSum,    64'd7);

        // Held result, then restart clears the totals.
        start_job(3);
        sb_q.push_back('{sum: 64'd666, pc: 35'd3, cnt: 32'd3, stray: 1'b0, ovf: 1'b0});
        send(38'd111, 3'd1);
        send(38'd222, 3'd1);
        send(38'd333, 3'd1);
        wait_result("held", 200, ok);
        if (ok) compare_result("held");
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("held.valid", bus.resultValid, 64'd1);
            check("held.sum",   bus.totalSum,    64'd666);
        end
        handshake("held");
        check("held.idle_sum", bus.totalSum, 64'd666);
        repeat (3) @(negedge clk);
        start_job(2);
        check("restart.sum",  bus.totalSum,        64'd0);
        check("restart.pc",   bus.totalPcoeff,     64'd0);
        check("restart.cnt",  bus.resultsReceived, 64'd0);
        check("restart.busy", bus.busy,            64'd1);
        sb_q.push_back('{sum: 64'd3, pc: 35'd3, cnt: 32'd2, stray: 1'b0, ovf: 1'b0});
        send(38'd1, 3'd1);
        send(38'd2, 3'd2);
        wait_result("restart", 200, ok);
        if (ok) compare_result("restart");
        handshake("restart");

        // Accumulator preloaded near 2^64 so the next add wraps.
        start_job(1);
        sb_q.push_back('{sum: 64'h10, pc: 35'd3, cnt: 32'd1, stray: 1'b0, ovf: 1'b1});
        send(38'h20, 3'd3);
        t0 = last_t;
        while (cyc < t0 + L - 1) @(negedge clk);
        force dut.total_sum_q = 64'hFFFF_FFFF_FFFF_FFF0;
        #1;
        release dut.total_sum_q;
        wait_result("ovf", 200, ok);
        if (ok) compare_result("ovf");
        handshake("ovf");

        // Reset after two of four results.
        start_job(4);
        t0 = cyc;
        for (int j = 0; j < 4; j++) send(38'd5, 3'd1);
        while (cyc < t0 + L + 2) @(negedge clk);
        check("rstmid.cnt_before", bus.resultsReceived, 64'd2);
        check("rstmid.sum_before", bus.totalSum,        64'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.busy",  bus.busy,            64'd0);
        check("rstmid.valid", bus.resultValid,     64'd0);
        check("rstmid.sum",   bus.totalSum,        64'd0);
        check("rstmid.pc",    bus.totalPcoeff,     64'd0);
        check("rstmid.cnt",   bus.resultsReceived, 64'd0);
        check("rstmid.ovf",   bus.sumOverflow,     64'd0);
        repeat (6) @(negedge clk);
        check("rstmid.no_stray", bus.strayResult,     64'd0);
        check("rstmid.no_acc",   bus.resultsReceived, 64'd0);

        // Long gapped stream.
        start_job(1000);
        sb_q.push_back('{sum: 64'd499500, pc: 35'd3500, cnt: 32'd1000,
                         stray: 1'b0, ovf: 1'b0});
        for (int i = 0; i < 1000; i++) begin
            send(38'(i), 3'(i % 8));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_result("gapped", 3000, ok);
        if (ok) compare_result("gapped");
        handshake("gapped");

        check("sb.empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
